line_scaler_buffer: RTL

- Parametrised ping-pong line buffer between the PPU pixel stream and the VGA/TMDS output path.
- Captures one source line into a free bank while the other bank is replayed to the display timing.
- Each source pixel is repeated H_SCALE times horizontally; each source line is repeated V_SCALE times vertically.
- Adds per-bank state tracking, border fill, and sticky overflow/underflow flags.

---
 rtl/line_scaler_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/line_scaler_buffer.sv
// Ping-pong line buffer: one bank captures a source line while the other replays it H_SCALE x V_SCALE.
// Output latency is 2 cycles from rd_de; wr_ready drops only when both banks hold a line or are replaying.
module line_scaler_buffer #(
  parameter int                DATA_W       = 24,
  parameter int                LINE_W       = 256,
  parameter int                ADDR_W       = 9,
  parameter int                H_SCALE      = 2,
  parameter int                V_SCALE      = 2,
  parameter logic [DATA_W-1:0] BORDER_COLOR = {DATA_W{1'b0}}
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sol,
  output logic              wr_ready,
  input  logic              rd_sol,
  input  logic              rd_de,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_de_out,
  input  logic              clr_flags,
  output logic              ovf,
  output logic              unf
);
  typedef enum logic [1:0] {ST_FREE, ST_FILLING, ST_FULL, ST_READING} bank_st_e;

  localparam int                DEPTH    = 2 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_W - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [2:0]        H_LAST   = 3'(H_SCALE - 1);
  localparam logic [2:0]        V_LAST   = 3'(V_SCALE - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  bank_st_e          bank_q [2];
  bank_st_e          bank_d [2];
  logic              wr_active_q, wr_active_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_bank_q, rd_bank_d;
  logic [2:0]        rep_q, rep_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [2:0]        sub_q, sub_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              s1_de_q, s1_de_d;
  logic              s1_pix_q, s1_pix_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_de_out_q, rd_de_out_d;

  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rd_addr;
  logic              avail0, avail1, wr_sel;
  logic              take_vld, take_bank, rd_other;
  logic              ovf_set, unf_set;

  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    wr_active_d = wr_active_q;
    wr_bank_d   = wr_bank_q;
    wr_ptr_d    = wr_ptr_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    avail0      = (bank_q[0] == ST_FREE) || (bank_q[0] == ST_FILLING);
    avail1      = (bank_q[1] == ST_FREE) || (bank_q[1] == ST_FILLING);
    wr_sel      = !avail0;
    ovf_set     = 1'b0;

    // Write side only ever touches FREE/FILLING banks, read side only FULL/READING: no overlap.
    if (wr_valid && wr_sol) begin
      if (bank_q[0] == ST_FILLING) bank_d[0] = ST_FREE;
      if (bank_q[1] == ST_FILLING) bank_d[1] = ST_FREE;
      if (avail0 || avail1) begin
        wr_en          = 1'b1;
        wr_addr        = {wr_sel, {ADDR_W{1'b0}}};
        wr_bank_d      = wr_sel;
        wr_ptr_d       = ONE_A;
        bank_d[wr_sel] = (LAST_IDX == '0) ? ST_FULL : ST_FILLING;
        wr_active_d    = (LAST_IDX != '0);
      end else begin
        ovf_set     = 1'b1;
        wr_active_d = 1'b0;
      end
    end else if (wr_valid && wr_active_q) begin
      wr_en   = 1'b1;
      wr_addr = {wr_bank_q, wr_ptr_q};
      if (wr_ptr_q == LAST_IDX) begin
        bank_d[wr_bank_q] = ST_FULL;
        wr_active_d       = 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q + ONE_A;
      end
    end

    rd_vld_d  = rd_vld_q;
    rd_bank_d = rd_bank_q;
    rep_d     = rep_q;
    src_d     = src_q;
    sub_d     = sub_q;
    done_d    = done_q;
    unf_set   = 1'b0;
    rd_other  = !rd_bank_q;
    take_vld  = 1'b0;
    take_bank = 1'b0;
    if (rd_vld_q) begin
      take_vld  = (bank_q[rd_other] == ST_FULL);
      take_bank = rd_other;
    end else if (bank_q[0] == ST_FULL) begin
      take_vld  = 1'b1;
      take_bank = 1'b0;
    end else if (bank_q[1] == ST_FULL) begin
      take_vld  = 1'b1;
      take_bank = 1'b1;
    end

    if (rd_sol) begin
      src_d  = '0;
      sub_d  = '0;
      done_d = 1'b0;
      if (rd_vld_q && (rep_q < V_LAST)) begin
        rep_d = rep_q + 3'd1;
      end else begin
        if (rd_vld_q) bank_d[rd_bank_q] = ST_FREE;
        rep_d    = '0;
        rd_vld_d = take_vld;
        if (take_vld) begin
          bank_d[take_bank] = ST_READING;
          rd_bank_d         = take_bank;
        end else begin
          unf_set = 1'b1;
        end
      end
    end else if (rd_de && !done_q) begin
      if (sub_q == H_LAST) begin
        sub_d = '0;
        if (src_q == LAST_IDX) done_d = 1'b1;
        else                   src_d  = src_q + ONE_A;
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end

    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    unf_d = unf_set | (unf_q & ~clr_flags);

    rd_addr     = {rd_bank_q, src_q};
    s1_de_d     = rd_de;
    s1_pix_d    = rd_de && rd_vld_q && !done_q;
    rd_de_out_d = s1_de_q;
    rd_data_d   = (s1_de_q && s1_pix_q) ? ram_rd_q : BORDER_COLOR;
  end

  // Storage is left unreset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    ram_rd_q <= mem[rd_addr];
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      bank_q[0]   <= ST_FREE;
      bank_q[1]   <= ST_FREE;
      wr_active_q <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
      rep_q       <= '0;
      src_q       <= '0;
      sub_q       <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      s1_de_q     <= 1'b0;
      s1_pix_q    <= 1'b0;
      rd_data_q   <= BORDER_COLOR;
      rd_de_out_q <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_active_q <= wr_active_d;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_vld_q    <= rd_vld_d;
      rd_bank_q   <= rd_bank_d;
      rep_q       <= rep_d;
      src_q       <= src_d;
      sub_q       <= sub_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      s1_de_q     <= s1_de_d;
      s1_pix_q    <= s1_pix_d;
      rd_data_q   <= rd_data_d;
      rd_de_out_q <= rd_de_out_d;
    end
  end

  assign wr_ready  = avail0 | avail1;
  assign rd_data   = rd_data_q;
  assign rd_de_out = rd_de_out_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule
